// File: rtl/wash_sequencer.sv
// Washing-machine program controller: fill, wash, drain, rinse loop, spin, buzzer.
// Advances on counted 1 Hz ticks; owns pause toggling and the finish indication.
//   state  | meaning
//   IDLE   | waiting for start, all outputs off
//   FILL   | inlet open          WASH   | drum agitating
//   DRAIN  | pump running        RFILL  | rinse-loop fill
//   RINSE  | rinse agitation     RDRAIN | rinse-loop drain, loop count decided
//   SPIN   | fast spin + pump    DONE   | finish/buzzer, then back to IDLE
module wash_sequencer #(
    parameter int FILL_SEC  = 3,
    parameter int WASH_SEC  = 10,
    parameter int DRAIN_SEC = 3,
    parameter int RINSE_SEC = 5,
    parameter int SPIN_SEC  = 6,
    parameter int RINSE_CNT = 2,
    parameter int BUZZ_SEC  = 3,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_1hz,
    input  logic          power_on,
    input  logic          start_btn,
    input  logic          pause_btn,
    output logic          water_in,
    output logic          drain,
    output logic          motor,
    output logic          spin_fast,
    output logic [3:0]    stage_led,
    output logic          pause_led,
    output logic          finish,
    output logic          buzzer,
    output logic [CW-1:0] sec_left,
    output logic [2:0]    rinse_left
);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN, S_SPIN, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] sec_nxt;
    logic [2:0]    rinse_nxt;
    logic          paused, paused_nxt;
    logic          ct;

    function automatic logic [CW-1:0] dur(input state_t s);
        case (s)
            S_FILL, S_RFILL:  dur = CW'(FILL_SEC);
            S_WASH:           dur = CW'(WASH_SEC);
            S_DRAIN, S_RDRAIN: dur = CW'(DRAIN_SEC);
            S_RINSE:          dur = CW'(RINSE_SEC);
            S_SPIN:           dur = CW'(SPIN_SEC);
            S_DONE:           dur = CW'(BUZZ_SEC);
            default:          dur = '0;
        endcase
    endfunction

    // A tick that lands on a pause/resume press is dropped either way.
    assign ct = tick_1hz & ~paused & ~pause_btn & power_on;

    always_comb begin
        state_nxt  = state;
        sec_nxt    = sec_left;
        rinse_nxt  = rinse_left;
        paused_nxt = paused;
        case (state)
            S_IDLE: begin
                paused_nxt = 1'b0;
                if (start_btn) begin
                    state_nxt = S_FILL;
                    sec_nxt   = CW'(FILL_SEC);
                    rinse_nxt = 3'(RINSE_CNT);
                end
            end
            S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN, S_SPIN: begin
                if (pause_btn) begin
                    paused_nxt = ~paused;
                end else if (ct) begin
                    if (sec_left > CW'(1)) begin
                        sec_nxt = sec_left - CW'(1);
                    end else begin
                        case (state)
                            S_FILL:  state_nxt = S_WASH;
                            S_WASH:  state_nxt = S_DRAIN;
                            S_DRAIN: state_nxt = S_RFILL;
                            S_RFILL: state_nxt = S_RINSE;
                            S_RINSE: state_nxt = S_RDRAIN;
                            S_RDRAIN: begin
                                rinse_nxt = rinse_left - 3'd1;
                                state_nxt = (rinse_left > 3'd1) ? S_RFILL : S_SPIN;
                            end
                            S_SPIN:  state_nxt = S_DONE;
                            default: state_nxt = S_IDLE;
                        endcase
                        sec_nxt = dur(state_nxt);
                        if (state_nxt == S_DONE) paused_nxt = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (ct) begin
                    if (sec_left > CW'(1)) begin
                        sec_nxt = sec_left - CW'(1);
                    end else begin
                        state_nxt = S_IDLE;
                        sec_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                sec_nxt    = '0;
                rinse_nxt  = '0;
                paused_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n || !power_on) begin
            state      <= S_IDLE;
            sec_left   <= '0;
            rinse_left <= '0;
            paused     <= 1'b0;
            water_in   <= 1'b0;
            drain      <= 1'b0;
            motor      <= 1'b0;
            spin_fast  <= 1'b0;
            stage_led  <= '0;
            pause_led  <= 1'b0;
            finish     <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_nxt;
            sec_left   <= sec_nxt;
            rinse_left <= rinse_nxt;
            paused     <= paused_nxt;
            water_in   <= ~paused_nxt & (state_nxt == S_FILL || state_nxt == S_RFILL);
            drain      <= ~paused_nxt & (state_nxt == S_DRAIN || state_nxt == S_RDRAIN ||
                                         state_nxt == S_SPIN);
            motor      <= ~paused_nxt & (state_nxt == S_WASH || state_nxt == S_RINSE ||
                                         state_nxt == S_SPIN);
            spin_fast  <= ~paused_nxt & (state_nxt == S_SPIN);
            stage_led  <= {state_nxt == S_SPIN, state_nxt == S_RINSE, state_nxt == S_WASH,
                           (state_nxt == S_FILL || state_nxt == S_DRAIN ||
                            state_nxt == S_RFILL || state_nxt == S_RDRAIN)};
            pause_led  <= paused_nxt;
            finish     <= (state_nxt == S_DONE);
            buzzer     <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the selected instance.
module tb_wash_sequencer;

    localparam int IDLE = 0, FILL = 1, WASH = 2, DRAIN = 3, RFILL = 4,
                   RINSE = 5, RDRAIN = 6, SPIN = 7, DONE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_1hz = 1'b0, power_on = 1'b1, start_btn = 1'b0, pause_btn = 1'b0;

    logic       w1, d1, m1, sf1, pl1, f1, b1;
    logic [3:0] led1;
    logic [7:0] sec1;
    logic [2:0] rin1;
    logic       w2, d2, m2, sf2, pl2, f2, b2;
    logic [3:0] led2;
    logic [7:0] sec2;
    logic [2:0] rin2;

    wash_sequencer dut1 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .power_on(power_on),
        .start_btn(start_btn), .pause_btn(pause_btn),
        .water_in(w1), .drain(d1), .motor(m1), .spin_fast(sf1), .stage_led(led1),
        .pause_led(pl1), .finish(f1), .buzzer(b1), .sec_left(sec1), .rinse_left(rin1)
    );

    wash_sequencer #(.RINSE_CNT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .power_on(power_on),
        .start_btn(start_btn), .pause_btn(pause_btn),
        .water_in(w2), .drain(d2), .motor(m2), .spin_fast(sf2), .stage_led(led2),
        .pause_led(pl2), .finish(f2), .buzzer(b2), .sec_left(sec2), .rinse_left(rin2)
    );

    always #5 clk = ~clk;

    logic [21:0] vec1, vec2;
    assign vec1 = {w1, d1, m1, sf1, led1, pl1, f1, b1, sec1, rin1};
    assign vec2 = {w2, d2, m2, sf2, led2, pl2, f2, b2, sec2, rin2};

    logic [21:0] q_exp[$];
    string       q_name[$];
    int          q_dut[$];
    int          checks = 0, passed = 0;
    int          direct_fail = 0;

    function automatic logic [21:0] exp_vec(input int st, input int sec, input int rinse,
                                            input logic pz);
        logic       w, d, m, sf, fb;
        logic [3:0] led;
        w   = (st == FILL || st == RFILL) && !pz;
        d   = (st == DRAIN || st == RDRAIN || st == SPIN) && !pz;
        m   = (st == WASH || st == RINSE || st == SPIN) && !pz;
        sf  = (st == SPIN) && !pz;
        fb  = (st == DONE);
        led = 4'b0000;
        if (st == FILL || st == DRAIN || st == RFILL || st == RDRAIN) led = 4'b0001;
        if (st == WASH)  led = 4'b0010;
        if (st == RINSE) led = 4'b0100;
        if (st == SPIN)  led = 4'b1000;
        return {w, d, m, sf, led, pz, fb, fb, 8'(sec), 3'(rinse)};
    endfunction

    task automatic expect_st(input int dut, input string name, input int st, input int sec,
                             input int rinse, input logic pz);
        q_exp.push_back(exp_vec(st, sec, rinse, pz));
        q_name.push_back(name);
        q_dut.push_back(dut);
    endtask

    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            logic [21:0] e, a;
            string       n;
            int          u;
            e = q_exp.pop_front();
            n = q_name.pop_front();
            u = q_dut.pop_front();
            a = (u == 0) ? vec1 : vec2;
            checks++;
            if (a === e) passed++;
            else $display("FAIL %s dut%0d: got %h expected %h", n, u + 1, a, e);
        end
    end

    task automatic cyc(input logic t, input logic s, input logic p);
        tick_1hz  = t;
        start_btn = s;
        pause_btn = p;
        @(posedge clk);
        #1;
        tick_1hz  = 1'b0;
        start_btn = 1'b0;
        pause_btn = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct packed {int t; int st; int sec; int rinse;} cp_t;
    cp_t cps1[12];
    cp_t cps2[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cps1 = '{'{3, WASH, 10, 2}, '{13, DRAIN, 3, 2}, '{16, RFILL, 3, 2},
                 '{19, RINSE, 5, 2}, '{24, RDRAIN, 3, 2}, '{26, RDRAIN, 1, 2},
                 '{27, RFILL, 3, 1}, '{38, SPIN, 6, 0}, '{43, SPIN, 1, 0},
                 '{44, DONE, 3, 0}, '{46, DONE, 1, 0}, '{47, IDLE, 0, 0}};
        cps2 = '{'{16, RFILL, 3, 1}, '{24, RDRAIN, 3, 1}, '{27, SPIN, 6, 0},
                 '{32, SPIN, 1, 0}, '{33, DONE, 3, 0}};

        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0);
        expect_st(0, "reset_idle", IDLE, 0, 0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        expect_st(0, "idle_pause_tick_ignored", IDLE, 0, 0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0);
        expect_st(0, "start_fill", FILL, 3, 2, 1'b0);
        for (int t = 1; t <= 47; t++) begin
            cyc(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 12; k++)
                if (cps1[k].t == t)
                    expect_st(0, "seq_default", cps1[k].st, cps1[k].sec, cps1[k].rinse, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            if (t == 40) begin
                cyc(1'b0, 1'b1, 1'b0);
                expect_st(0, "start_in_spin", SPIN, 4, 0, 1'b0);
            end
            if (t == 45) begin
                cyc(1'b0, 1'b0, 1'b1);
                expect_st(0, "pause_in_done", DONE, 2, 0, 1'b0);
            end
        end
        cyc(1'b0, 1'b0, 1'b1);
        expect_st(0, "pause_in_idle", IDLE, 0, 0, 1'b0);

        do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        expect_st(0, "start_and_pause", FILL, 3, 2, 1'b0);
        ticks(6);
        expect_st(0, "wash_7", WASH, 7, 2, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        expect_st(0, "paused_wash", WASH, 7, 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            expect_st(0, "paused_hold", WASH, 7, 2, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        expect_st(0, "resumed_wash", WASH, 7, 2, 1'b0);
        for (int t = 7; t <= 44; t++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (t == 12) expect_st(0, "wash_last", WASH, 1, 2, 1'b0);
            if (t == 13) expect_st(0, "drain_after_pause", DRAIN, 3, 2, 1'b0);
            if (t == 44) expect_st(0, "done_after_pause", DONE, 3, 0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end

        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(9);
        expect_st(0, "wash_4", WASH, 4, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        expect_st(0, "collide_pause", WASH, 4, 2, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        expect_st(0, "collide_resume", WASH, 4, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expect_st(0, "tick_after_resume", WASH, 3, 2, 1'b0);

        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(31);
        expect_st(0, "rinse_loop2", RINSE, 4, 1, 1'b0);
        power_on = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        expect_st(0, "power_drop", IDLE, 0, 0, 1'b0);
        if (w1 !== 1'b0 || d1 !== 1'b0 || m1 !== 1'b0 || sf1 !== 1'b0) begin
            direct_fail++;
            $display("FAIL power_drop_actuators: w=%b d=%b m=%b sf=%b", w1, d1, m1, sf1);
        end
        if (rin1 !== 3'd0) begin
            direct_fail++;
            $display("FAIL power_drop_rinse: rinse_left=%0d", rin1);
        end
        power_on = 1'b1;
        ticks(5);
        expect_st(0, "power_return_idle", IDLE, 0, 0, 1'b0);

        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(14);
        expect_st(0, "drain_2", DRAIN, 2, 2, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        expect_st(0, "reset_mid_drain", IDLE, 0, 0, 1'b0);
        rst_n = 1'b1;
        ticks(3);
        expect_st(0, "idle_after_reset", IDLE, 0, 0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0);
        expect_st(1, "rc1_start", FILL, 3, 1, 1'b0);
        for (int t = 1; t <= 33; t++) begin
            cyc(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 5; k++)
                if (cps2[k].t == t)
                    expect_st(1, "seq_rinse1", cps2[k].st, cps2[k].sec, cps2[k].rinse, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        if (checks < 12) begin
            direct_fail++;
            $display("FAIL too few checks executed: %0d", checks);
        end
        if (passed != checks || direct_fail != 0)
            $display("FAIL %0d scoreboard mismatches, %0d direct failures",
                     checks - passed, direct_fail);
        else
            $display("PASS");
        $finish;
    end

endmodule
